// File: rtl/key_digit_capture.sv
// Synchronises and debounces two active-low keys; each debounced press captures
// one switch nibble into a held digit and sets that digit's show flag.
module key_digit_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [1:0] KEY,
    input  logic [7:0] SW,
    output logic [3:0] DIG3,
    output logic [3:0] DIG2,
    output logic       VAL3,
    output logic       VAL2,
    output logic [1:0] PRESS
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       key_sync_p0;
    logic [1:0]       key_sync_p1;
    logic [7:0]       sw_sync_p0;
    logic [7:0]       sw_sync_p1;
    logic [1:0]       stable;
    logic [1:0]       stable_p2;
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       press_evt;

    // Stage p0/p1: two-flop synchronisers for the asynchronous keys and switches
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            key_sync_p0 <= 2'b11;
            key_sync_p1 <= 2'b11;
            sw_sync_p0  <= '0;
            sw_sync_p1  <= '0;
        end else begin
            key_sync_p0 <= KEY;
            key_sync_p1 <= key_sync_p0;
            sw_sync_p0  <= SW;
            sw_sync_p1  <= sw_sync_p0;
        end
    end

    // Per-key debounce: any return to the stable level restarts the count
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            stable <= 2'b11;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (key_sync_p1[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TERM) begin
                    stable[i] <= key_sync_p1[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is a falling edge of the debounced level; releases are ignored
    assign press_evt = stable_p2 & ~stable;

    // Stage p2: press pulse and digit capture
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            stable_p2 <= 2'b11;
            PRESS     <= 2'b00;
            DIG3      <= 4'h0;
            DIG2      <= 4'h0;
            VAL3      <= 1'b0;
            VAL2      <= 1'b0;
        end else begin
            stable_p2 <= stable;
            PRESS     <= press_evt;
            if (press_evt[1]) begin
                DIG3 <= sw_sync_p1[7:4];
                VAL3 <= 1'b1;
            end
            if (press_evt[0]) begin
                DIG2 <= sw_sync_p1[3:0];
                VAL2 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_digit_capture.sv
// Directed bench for key_digit_capture with a short debounce window of 4 cycles.
module tb_key_digit_capture;

    logic       clk;
    logic       rst;
    logic [1:0] key;
    logic [7:0] sw;
    logic [3:0] dig3;
    logic [3:0] dig2;
    logic       val3;
    logic       val2;
    logic [1:0] press;

    int tests;
    int fails;

    key_digit_capture #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .CLOCK_50(clk),
        .Reset   (rst),
        .KEY     (key),
        .SW      (sw),
        .DIG3    (dig3),
        .DIG2    (dig2),
        .VAL3    (val3),
        .VAL2    (val2),
        .PRESS   (press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then stop on the falling edge to sample and drive
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key = 2'b11;
        sw  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            tests++;
            if ({dig3, dig2, val3, val2, press} !== 12'h000) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got dig3=%h dig2=%h val3=%b val2=%b press=%b, want all zero",
                         k, dig3, dig2, val3, val2, press);
            end
        end
    endtask

    task automatic test_press_key1();
        sw = 8'hA0;
        repeat (3) tick();
        key = 2'b01;
        for (int k = 0; k < 9; k++) begin
            tick();
            tests++;
            if (press !== ((k == 6) ? 2'b10 : 2'b00)) begin
                fails++;
                $display("FAIL press1_timing edge %0d: got press=%b, want %b",
                         k, press, (k == 6) ? 2'b10 : 2'b00);
            end
        end
        tests++;
        if ({dig3, val3, val2, dig2} !== {4'hA, 1'b1, 1'b0, 4'h0}) begin
            fails++;
            $display("FAIL press1_capture: got dig3=%h val3=%b val2=%b dig2=%h, want A 1 0 0",
                     dig3, val3, val2, dig2);
        end
        key = 2'b11;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests++;
            if (press !== 2'b00) begin
                fails++;
                $display("FAIL press1_release edge %0d: got press=%b, want 00", k, press);
            end
        end
        tests++;
        if ({dig3, val3} !== {4'hA, 1'b1}) begin
            fails++;
            $display("FAIL press1_hold_after_release: got dig3=%h val3=%b, want A 1", dig3, val3);
        end
    endtask

    task automatic test_bounce();
        logic [1:0] pattern [18];
        for (int k = 0; k < 18; k++) pattern[k] = 2'b11;
        for (int k = 0; k < 3; k++) pattern[k] = 2'b10;
        for (int k = 5; k < 8; k++) pattern[k] = 2'b10;
        for (int k = 0; k < 18; k++) begin
            key = pattern[k];
            tick();
            tests++;
            if (press !== 2'b00) begin
                fails++;
                $display("FAIL bounce_no_pulse step %0d: got press=%b, want 00", k, press);
            end
        end
        tests++;
        if ({dig2, val2} !== {4'h0, 1'b0}) begin
            fails++;
            $display("FAIL bounce_digit: got dig2=%h val2=%b, want 0 0", dig2, val2);
        end
    endtask

    task automatic test_hold();
        int pulses;
        int pulse_edge;
        pulses     = 0;
        pulse_edge = -1;
        sw = 8'h03;
        repeat (3) tick();
        key = 2'b10;
        for (int k = 0; k < 50; k++) begin
            if (k == 20) sw = 8'h07;
            tick();
            if (press[0] === 1'b1) begin
                pulses++;
                pulse_edge = k;
            end
            tests++;
            if (press[1] !== 1'b0) begin
                fails++;
                $display("FAIL hold_other_key edge %0d: got press=%b, want press[1]=0", k, press);
            end
        end
        tests++;
        if (pulses != 1 || pulse_edge != 6) begin
            fails++;
            $display("FAIL hold_single_pulse: got %0d pulses (last at edge %0d), want 1 at edge 6",
                     pulses, pulse_edge);
        end
        tests++;
        if ({dig2, val2, dig3} !== {4'h3, 1'b1, 4'hA}) begin
            fails++;
            $display("FAIL hold_capture: got dig2=%h val2=%b dig3=%h, want 3 1 A", dig2, val2, dig3);
        end
        key    = 2'b11;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (press !== 2'b00) pulses++;
        end
        tests++;
        if (pulses != 0 || dig2 !== 4'h3) begin
            fails++;
            $display("FAIL hold_release: got %0d pulses dig2=%h, want 0 pulses dig2=3", pulses, dig2);
        end
    endtask

    task automatic test_simultaneous();
        sw = 8'hF1;
        repeat (3) tick();
        key = 2'b00;
        for (int k = 0; k < 9; k++) begin
            tick();
            tests++;
            if (press !== ((k == 6) ? 2'b11 : 2'b00)) begin
                fails++;
                $display("FAIL simul_timing edge %0d: got press=%b, want %b",
                         k, press, (k == 6) ? 2'b11 : 2'b00);
            end
        end
        tests++;
        if ({dig3, dig2, val3, val2} !== {4'hF, 4'h1, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL simul_capture: got dig3=%h dig2=%h val3=%b val2=%b, want F 1 1 1",
                     dig3, dig2, val3, val2);
        end
        key = 2'b11;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        key = 2'b01;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({dig3, dig2, val3, val2, press} !== 12'h000) begin
            fails++;
            $display("FAIL midreset_clear: got dig3=%h dig2=%h val3=%b val2=%b press=%b, want all zero",
                     dig3, dig2, val3, val2, press);
        end
        for (int k = 0; k < 9; k++) begin
            tick();
            tests++;
            if (press !== ((k == 6) ? 2'b10 : 2'b00)) begin
                fails++;
                $display("FAIL midreset_timing edge %0d: got press=%b, want %b",
                         k, press, (k == 6) ? 2'b10 : 2'b00);
            end
        end
        tests++;
        if ({dig3, val3, dig2, val2} !== {4'hF, 1'b1, 4'h0, 1'b0}) begin
            fails++;
            $display("FAIL midreset_capture: got dig3=%h val3=%b dig2=%h val2=%b, want F 1 0 0",
                     dig3, val3, dig2, val2);
        end
        key = 2'b11;
        repeat (10) tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        key   = 2'b11;
        sw    = 8'h00;
        @(negedge clk);
        test_reset();
        test_press_key1();
        test_bounce();
        test_hold();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
